mem2axi: RTL and testbench
==========================

# mem2axi

Bridges the core-side single-word memory port (req/gnt, we, addr, be, data) onto an AXI4 master, issuing one single-beat AXI transaction per accepted request. It sits between a simple memory-request initiator and the AXI interconnect that feeds the DRAM-side slave bridge. It holds at most one transaction in flight and returns a one-cycle response pulse carrying read data or write acknowledge, plus an error flag.

## Interface

- AXI_ID_WIDTH, 10, AXI ID width
- AXI_ADDR_WIDTH, 64, address width
- AXI_DATA_WIDTH, 64, data width; LOG_NR_BYTES = $clog2(AXI_DATA_WIDTH/8)
- AXI_USER_WIDTH, 10, user width
- TXN_ID, 0, constant ID driven on ar_id/aw_id

- clk_i  in  1  clock; single clock domain
- rst_i  in  1  asynchronous, active-high reset
- req_i  in  1  request valid; held with its payload until gnt_o
- gnt_o  out  1  request accepted this cycle
- we_i  in  1  1 = write, 0 = read
- addr_i  in  AXI_ADDR_WIDTH  byte address
- be_i  in  AXI_DATA_WIDTH/8  write byte enables
- wdata_i  in  AXI_DATA_WIDTH  write data
- rvalid_o  out  1  one-cycle response pulse (read data or write ack)
- rdata_o  out  AXI_DATA_WIDTH  read data, valid with rvalid_o
- err_o  out  1  response error, valid with rvalid_o
- master  AXI_BUS.Master  AXI4 master port

## Operation

- States: IDLE, AR, R, AW_W, B.
- IDLE: gnt_o = req_i. On req_i: latch we, addr aligned (low LOG_NR_BYTES bits cleared), be, wdata; next AR if read, AW_W if write.
- AR: ar_valid=1, ar_addr=addr_q, ar_len=0, ar_size=LOG_NR_BYTES, ar_burst=INCR (2'b01), ar_id=TXN_ID. On ar_ready -> R.
- R: r_ready=1. On r_valid: register rdata_o=r_data, err_o = r_resp[1] | ~r_last | (r_id != TXN_ID); rvalid_o=1 next cycle; -> IDLE.
- AW_W: aw_valid = ~aw_done_q, w_valid = ~w_done_q; aw fields as AR with aw_*; w_data=wdata_q, w_strb=be_q, w_last=1. aw/w handshakes tracked independently in aw_done_q/w_done_q; either order or same cycle. When both complete (counting this cycle's handshakes) -> B, clear flags.
- B: b_ready=1. On b_valid: err_o = b_resp[1] | (b_id != TXN_ID); rvalid_o=1 next cycle, rdata_o unchanged; -> IDLE.
- All other AX fields (lock, cache, prot, qos, region, user, atop) and w_user driven 0.
- gnt_o=0 in every non-IDLE state; no request accepted while a transaction is outstanding.

## Timing

- Reset (rst_i high, async): state IDLE, all AXI valids/readies 0, gnt_o 0, rvalid_o 0, rdata_o 0, err_o 0, aw/w done flags 0, latched request 0.
- gnt_o combinational from req_i in IDLE; all AXI outputs registered-state driven (no combinational path from AXI inputs to AXI valids).
- Valids held stable with constant payload until handshake (AXI rule); payload from latched registers only.
- Min read latency: grant cycle N, ar_valid N+1, r handshake N+2, rvalid_o N+3.
- Min write latency: grant N, aw+w handshake N+1, b handshake N+2, rvalid_o N+3.
- rvalid_o exactly one cycle; state is IDLE in that cycle, so a new request may be granted concurrently (back-to-back throughput one txn per 3 cycles).
- Reset mid-transaction abandons it; no response pulse afterward.

## Test plan

- Read, zero-wait slave: req addr 0x8000_0013, we=0 -> ar_addr 0x8000_0010, ar_len 0, ar_size 3; r_data 0xDEAD_BEEF_0123_4567 -> rvalid_o one cycle with that data, err_o 0, 3 cycles after grant.
- Write, w before aw: w_ready=1 first cycle, aw_ready delayed 4 cycles -> w_valid drops after its handshake, aw_valid held stable 4 cycles, single b, rvalid_o pulse, err_o 0; w_strb equals be_i 0x0F.
- Write, aw and w same cycle, b_valid delayed 5 cycles, b_resp=2'b10 -> rvalid_o with err_o 1.
- Read response protocol faults: r_last=0 or r_id=TXN_ID+1 -> err_o 1 on rvalid_o.
- Back-to-back: req_i held high for write then read -> second gnt_o in same cycle as first rvalid_o; no gnt_o while busy.
- Async reset asserted in AR with ar_valid high -> ar_valid, gnt_o, rvalid_o low immediately (before clock edge); after release, IDLE and fresh request completes normally.

Source files
------------

// File: rtl/mem2axi_if.sv
// AXI4 bus bundle connecting the memory-port bridge to the interconnect.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_USER_WIDTH = 10
);
  logic [AXI_ID_WIDTH-1:0]     aw_id;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]                  aw_len;
  logic [2:0]                  aw_size;
  logic [1:0]                  aw_burst;
  logic                        aw_lock;
  logic [3:0]                  aw_cache;
  logic [2:0]                  aw_prot;
  logic [3:0]                  aw_qos;
  logic [3:0]                  aw_region;
  logic [5:0]                  aw_atop;
  logic [AXI_USER_WIDTH-1:0]   aw_user;
  logic                        aw_valid;
  logic                        aw_ready;

  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        w_last;
  logic [AXI_USER_WIDTH-1:0]   w_user;
  logic                        w_valid;
  logic                        w_ready;

  logic [AXI_ID_WIDTH-1:0]     b_id;
  logic [1:0]                  b_resp;
  logic [AXI_USER_WIDTH-1:0]   b_user;
  logic                        b_valid;
  logic                        b_ready;

  logic [AXI_ID_WIDTH-1:0]     ar_id;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]                  ar_len;
  logic [2:0]                  ar_size;
  logic [1:0]                  ar_burst;
  logic                        ar_lock;
  logic [3:0]                  ar_cache;
  logic [2:0]                  ar_prot;
  logic [3:0]                  ar_qos;
  logic [3:0]                  ar_region;
  logic [AXI_USER_WIDTH-1:0]   ar_user;
  logic                        ar_valid;
  logic                        ar_ready;

  logic [AXI_ID_WIDTH-1:0]     r_id;
  logic [AXI_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                  r_resp;
  logic                        r_last;
  logic [AXI_USER_WIDTH-1:0]   r_user;
  logic                        r_valid;
  logic                        r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid, input aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid, input w_ready,
    input b_id, b_resp, b_user, b_valid, output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid, input ar_ready,
    input r_id, r_data, r_resp, r_last, r_user, r_valid, output r_ready
  );

  modport Slave (
    input aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
          aw_qos, aw_region, aw_atop, aw_user, aw_valid, output aw_ready,
    input w_data, w_strb, w_last, w_user, w_valid, output w_ready,
    output b_id, b_resp, b_user, b_valid, input b_ready,
    input ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
          ar_qos, ar_region, ar_user, ar_valid, output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid, input r_ready
  );
endinterface

// File: rtl/mem2axi.sv
// Single-word memory port to AXI4 master bridge: one single-beat transaction
// in flight, answered by a one-cycle response pulse with data and error flag.
module mem2axi #(
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_USER_WIDTH = 10,
  parameter int unsigned TXN_ID         = 0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_i,
  output logic                        gnt_o,
  input  logic                        we_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] be_i,
  input  logic [AXI_DATA_WIDTH-1:0]   wdata_i,
  output logic                        rvalid_o,
  output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
  output logic                        err_o,
  AXI_BUS.Master                      master
);
  localparam int unsigned NR_BYTES     = AXI_DATA_WIDTH / 8;
  localparam int unsigned LOG_NR_BYTES = $clog2(NR_BYTES);
  localparam logic [AXI_ID_WIDTH-1:0]   ID         = AXI_ID_WIDTH'(TXN_ID);
  localparam logic [2:0]                SIZE       = 3'(LOG_NR_BYTES);
  localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = ~AXI_ADDR_WIDTH'(NR_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR   = 3'd1,
    R    = 3'd2,
    AW_W = 3'd3,
    B    = 3'd4
  } state_e;

  state_e                      state_q;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [NR_BYTES-1:0]         be_q;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q;
  logic                        aw_done_q;
  logic                        w_done_q;
  logic                        aw_fin;
  logic                        w_fin;

  // A channel is finished once it handshook earlier or is handshaking now.
  assign aw_fin = aw_done_q | master.aw_ready;
  assign w_fin  = w_done_q  | master.w_ready;

  assign gnt_o = ~rst_i & (state_q == IDLE) & req_i;

  assign master.ar_valid  = (state_q == AR);
  assign master.ar_addr   = addr_q;
  assign master.ar_len    = 8'd0;
  assign master.ar_size   = SIZE;
  assign master.ar_burst  = 2'b01;
  assign master.ar_id     = ID;
  assign master.ar_lock   = 1'b0;
  assign master.ar_cache  = 4'd0;
  assign master.ar_prot   = 3'd0;
  assign master.ar_qos    = 4'd0;
  assign master.ar_region = 4'd0;
  assign master.ar_user   = '0;
  assign master.r_ready   = (state_q == R);

  assign master.aw_valid  = (state_q == AW_W) & ~aw_done_q;
  assign master.aw_addr   = addr_q;
  assign master.aw_len    = 8'd0;
  assign master.aw_size   = SIZE;
  assign master.aw_burst  = 2'b01;
  assign master.aw_id     = ID;
  assign master.aw_lock   = 1'b0;
  assign master.aw_cache  = 4'd0;
  assign master.aw_prot   = 3'd0;
  assign master.aw_qos    = 4'd0;
  assign master.aw_region = 4'd0;
  assign master.aw_atop   = 6'd0;
  assign master.aw_user   = '0;

  assign master.w_valid   = (state_q == AW_W) & ~w_done_q;
  assign master.w_data    = wdata_q;
  assign master.w_strb    = be_q;
  assign master.w_last    = 1'b1;
  assign master.w_user    = '0;
  assign master.b_ready   = (state_q == B);

  // Transaction FSM with the latched request and registered response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rvalid_o  <= 1'b0;
      rdata_o   <= '0;
      err_o     <= 1'b0;
    end else begin
      rvalid_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_i) begin
            addr_q  <= addr_i & ALIGN_MASK;
            be_q    <= be_i;
            wdata_q <= wdata_i;
            state_q <= we_i ? AW_W : AR;
          end
        end
        AR: begin
          if (master.ar_ready) state_q <= R;
        end
        R: begin
          if (master.r_valid) begin
            rdata_o  <= master.r_data;
            err_o    <= master.r_resp[1] | ~master.r_last | (master.r_id != ID);
            rvalid_o <= 1'b1;
            state_q  <= IDLE;
          end
        end
        AW_W: begin
          if (aw_fin && w_fin) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            state_q   <= B;
          end else begin
            aw_done_q <= aw_fin;
            w_done_q  <= w_fin;
          end
        end
        B: begin
          if (master.b_valid) begin
            err_o    <= master.b_resp[1] | (master.b_id != ID);
            rvalid_o <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem2axi.sv
// Randomized bench for mem2axi: an AXI slave with per-transaction delays and a
// transaction-level model checked against the DUT on every falling clock edge.
module tb_mem2axi;
  localparam int unsigned IDW = 10;
  localparam int unsigned AW  = 64;
  localparam int unsigned DW  = 64;
  localparam int unsigned UW  = 10;
  localparam int unsigned SW  = DW / 8;

  typedef struct {
    int unsigned    ar_dly, aw_dly, w_dly, r_dly, b_dly;
    logic [DW-1:0]  rdata;
    logic [1:0]     rresp;
    logic           rlast;
    logic [IDW-1:0] rid;
    logic [1:0]     bresp;
    logic [IDW-1:0] bid;
  } cfg_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [SW-1:0] be = '0;
  logic [DW-1:0] wdata = '0;
  logic          gnt, rvalid, err;
  logic [DW-1:0] rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  AXI_BUS #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IDW), .AXI_USER_WIDTH(UW)) axi ();

  mem2axi #(
    .AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_USER_WIDTH(UW), .TXN_ID(0)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .we_i(we), .addr_i(addr),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err), .master(axi)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- AXI slave ----------------
  cfg_t        cfg_q[$];
  cfg_t        cur;
  bit          active, r_pend, b_pend, aw_got, w_got;
  bit          p_ar, p_aw, p_w, p_r, p_b;
  int unsigned ar_w, aw_w, w_w, r_w, b_w;

  task automatic slave_idle();
    active = 0; r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
    p_ar = 0; p_aw = 0; p_w = 0; p_r = 0; p_b = 0;
    axi.ar_ready = 1'b0; axi.aw_ready = 1'b0; axi.w_ready = 1'b0;
    axi.r_valid = 1'b0; axi.b_valid = 1'b0;
  endtask

  task automatic slave_step();
    if (rst) begin
      slave_idle();
    end else begin
      if (p_ar) begin r_pend = 1; r_w = 0; end
      if (p_r) begin r_pend = 0; active = 0; end
      if (p_b) begin b_pend = 0; active = 0; end
      if (p_aw) aw_got = 1;
      if (p_w) w_got = 1;
      if (aw_got && w_got) begin b_pend = 1; b_w = 0; aw_got = 0; w_got = 0; end
      if (!active && (axi.ar_valid || axi.aw_valid || axi.w_valid) && cfg_q.size() != 0) begin
        cur = cfg_q.pop_front();
        active = 1; ar_w = 0; aw_w = 0; w_w = 0;
      end
      axi.ar_ready = axi.ar_valid && (ar_w >= cur.ar_dly);
      if (axi.ar_valid) ar_w++;
      axi.aw_ready = axi.aw_valid && (aw_w >= cur.aw_dly);
      if (axi.aw_valid) aw_w++;
      axi.w_ready = axi.w_valid && (w_w >= cur.w_dly);
      if (axi.w_valid) w_w++;
      axi.r_valid = r_pend && (r_w >= cur.r_dly);
      if (r_pend) r_w++;
      axi.r_data = cur.rdata; axi.r_resp = cur.rresp; axi.r_last = cur.rlast; axi.r_id = cur.rid;
      axi.b_valid = b_pend && (b_w >= cur.b_dly);
      if (b_pend) b_w++;
      axi.b_resp = cur.bresp; axi.b_id = cur.bid;
      p_ar = axi.ar_valid && axi.ar_ready;
      p_aw = axi.aw_valid && axi.aw_ready;
      p_w  = axi.w_valid && axi.w_ready;
      p_r  = axi.r_valid && axi.r_ready;
      p_b  = axi.b_valid && axi.b_ready;
    end
  endtask

  initial begin
    cur = '{default: 0};
    axi.r_data = '0; axi.r_resp = 2'b00; axi.r_last = 1'b0; axi.r_id = '0; axi.r_user = '0;
    axi.b_resp = 2'b00; axi.b_id = '0; axi.b_user = '0;
    slave_idle();
    forever begin
      @(posedge clk);
      #1;
      slave_step();
    end
  end

  // ---------------- transaction model + compare ----------------
  bit            m_busy, m_we, m_ar_acc, m_aw_acc, m_w_acc, m_resp, m_err;
  logic [AW-1:0] m_addr;
  logic [SW-1:0] m_be;
  logic [DW-1:0] m_wdata, m_rdata, m_last_rdata;
  int            last_grant_cyc, last_rv_cyc, overlap_cnt, aw_cyc, w_cyc, b_cnt;
  logic [AW-1:0] last_ar_addr;
  logic [2:0]    last_ar_size;
  logic [SW-1:0] last_strb;

  task automatic compare_step();
    logic [63:0] act_f;
    bit rd, wr;
    if (rst) begin
      check("rst_gnt", gnt, 1'b0);
      check("rst_rvalid", rvalid, 1'b0);
      check("rst_rdata", rdata, 64'd0);
      check("rst_err", err, 1'b0);
      check("rst_valids", {axi.ar_valid, axi.aw_valid, axi.w_valid, axi.r_ready, axi.b_ready}, 64'd0);
      m_busy = 0; m_resp = 0; m_last_rdata = '0;
      return;
    end
    rd = m_busy && !m_we;
    wr = m_busy && m_we;
    check("gnt", gnt, req && !m_busy);
    check("rvalid", rvalid, m_resp);
    if (m_resp) begin
      check("rdata", rdata, m_rdata);
      check("err", err, m_err);
      last_rv_cyc = cyc;
      if (gnt) overlap_cnt++;
    end
    check("ar_valid", axi.ar_valid, rd && !m_ar_acc);
    check("r_ready", axi.r_ready, rd && m_ar_acc);
    check("aw_valid", axi.aw_valid, wr && !m_aw_acc);
    check("w_valid", axi.w_valid, wr && !m_w_acc);
    check("b_ready", axi.b_ready, wr && m_aw_acc && m_w_acc);
    if (axi.ar_valid) begin
      check("ar_addr", axi.ar_addr, m_addr);
      act_f = {15'd0, axi.ar_len, axi.ar_size, axi.ar_burst, axi.ar_id, axi.ar_lock,
               axi.ar_cache, axi.ar_prot, axi.ar_qos, axi.ar_region, axi.ar_user};
      check("ar_fields", act_f, {15'd0, 8'd0, 3'd3, 2'b01, 10'd0, 26'd0});
    end
    if (axi.aw_valid) begin
      aw_cyc++;
      check("aw_addr", axi.aw_addr, m_addr);
      act_f = {9'd0, axi.aw_len, axi.aw_size, axi.aw_burst, axi.aw_id, axi.aw_lock, axi.aw_cache,
               axi.aw_prot, axi.aw_qos, axi.aw_region, axi.aw_atop, axi.aw_user};
      check("aw_fields", act_f, {9'd0, 8'd0, 3'd3, 2'b01, 10'd0, 32'd0});
    end
    if (axi.w_valid) begin
      w_cyc++;
      check("w_data", axi.w_data, m_wdata);
      check("w_fields", {45'd0, axi.w_strb, axi.w_last, axi.w_user}, {45'd0, m_be, 1'b1, 10'd0});
    end
    m_resp = 0;
    if (axi.ar_valid && axi.ar_ready) begin
      m_ar_acc = 1; last_ar_addr = axi.ar_addr; last_ar_size = axi.ar_size;
    end
    if (axi.aw_valid && axi.aw_ready) m_aw_acc = 1;
    if (axi.w_valid && axi.w_ready) begin m_w_acc = 1; last_strb = axi.w_strb; end
    if (axi.r_valid && axi.r_ready) begin
      m_resp = 1; m_busy = 0; m_rdata = axi.r_data; m_last_rdata = axi.r_data;
      m_err = axi.r_resp[1] || !axi.r_last || (axi.r_id != 10'd0);
    end
    if (axi.b_valid && axi.b_ready) begin
      b_cnt++;
      m_resp = 1; m_busy = 0; m_rdata = m_last_rdata;
      m_err = axi.b_resp[1] || (axi.b_id != 10'd0);
    end
    if (req && gnt) begin
      m_busy = 1; m_we = we; m_addr = {addr[AW-1:3], 3'b000}; m_be = be; m_wdata = wdata;
      m_ar_acc = 0; m_aw_acc = 0; m_w_acc = 0;
      last_grant_cyc = cyc; aw_cyc = 0; w_cyc = 0; b_cnt = 0;
    end
  endtask

  initial begin
    m_last_rdata = '0; overlap_cnt = 0;
    forever begin
      @(negedge clk);
      cyc++;
      compare_step();
    end
  end

  // ---------------- requester ----------------
  task automatic make_cfg(output cfg_t c, input bit rnd);
    c = '{default: 0};
    c.rlast = 1'b1;
    if (rnd) begin
      c.ar_dly = $urandom_range(0, 3); c.aw_dly = $urandom_range(0, 3);
      c.w_dly  = $urandom_range(0, 3); c.r_dly  = $urandom_range(0, 3);
      c.b_dly  = $urandom_range(0, 3);
      c.rdata  = {$urandom, $urandom};
      c.rresp  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      c.rlast  = ($urandom_range(0, 7) != 0);
      c.rid    = ($urandom_range(0, 7) == 0) ? 10'd1 : 10'd0;
      c.bresp  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      c.bid    = ($urandom_range(0, 7) == 0) ? 10'd3 : 10'd0;
    end
  endtask

  // Entered just after a rising edge; returns just after the grant's edge.
  task automatic issue(input bit w, input logic [AW-1:0] a, input logic [SW-1:0] b,
                       input logic [DW-1:0] d, input cfg_t c, input bit keep);
    int n = 0;
    cfg_q.push_back(c);
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    do begin @(negedge clk); n++; end while (!gnt && n < 50);
    check("gnt_wait", gnt, 1'b1);
    @(posedge clk);
    #1;
    if (!keep) req = 1'b0;
  endtask

  task automatic wait_resp();
    int n = 0;
    do begin @(negedge clk); n++; end while (!rvalid && n < 60);
    check("resp_wait", rvalid, 1'b1);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    cfg_t c;
    int   ov0;
    bit   keep;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // zero-wait read with unaligned address
    make_cfg(c, 0); c.rdata = 64'hDEAD_BEEF_0123_4567;
    issue(1'b0, 64'h8000_0013, 8'h00, 64'd0, c, 1'b0);
    wait_resp();
    check("t1_rdata", rdata, 64'hDEAD_BEEF_0123_4567);
    check("t1_err", err, 1'b0);
    settle();
    check("t1_latency", last_rv_cyc - last_grant_cyc, 64'd3);
    check("t1_ar_addr", last_ar_addr, 64'h8000_0010);
    check("t1_ar_size", last_ar_size, 64'd3);

    // write, w accepted first, aw accepted after 4 stalled cycles
    make_cfg(c, 0); c.aw_dly = 4;
    issue(1'b1, 64'h0000_1238, 8'h0F, 64'h1122_3344_5566_7788, c, 1'b0);
    wait_resp();
    check("t2_err", err, 1'b0);
    check("t2_rdata_kept", rdata, 64'hDEAD_BEEF_0123_4567);
    settle();
    check("t2_latency", last_rv_cyc - last_grant_cyc, 64'd7);
    check("t2_aw_cycles", aw_cyc, 64'd5);
    check("t2_w_cycles", w_cyc, 64'd1);
    check("t2_b_count", b_cnt, 64'd1);
    check("t2_strb", last_strb, 64'h0F);

    // write, aw+w together, slow SLVERR response
    make_cfg(c, 0); c.b_dly = 5; c.bresp = 2'b10;
    issue(1'b1, 64'h0000_2000, 8'hFF, 64'hA5A5_A5A5_5A5A_5A5A, c, 1'b0);
    wait_resp();
    check("t3_err", err, 1'b1);
    settle();
    check("t3_latency", last_rv_cyc - last_grant_cyc, 64'd8);

    // read protocol faults
    make_cfg(c, 0); c.rlast = 1'b0; c.rdata = 64'h0000_0000_0000_1111;
    issue(1'b0, 64'h0000_3000, 8'h00, 64'd0, c, 1'b0);
    wait_resp();
    check("t4_nolast_err", err, 1'b1);
    check("t4_nolast_data", rdata, 64'h0000_0000_0000_1111);
    settle();
    make_cfg(c, 0); c.rid = 10'd1;
    issue(1'b0, 64'h0000_3008, 8'h00, 64'd0, c, 1'b0);
    wait_resp();
    check("t4_badid_err", err, 1'b1);
    settle();

    // back-to-back write then read with req held high
    ov0 = overlap_cnt;
    make_cfg(c, 0);
    issue(1'b1, 64'h0000_4000, 8'hF0, 64'h0102_0304_0506_0708, c, 1'b1);
    make_cfg(c, 0); c.rdata = 64'h7777_6666_5555_4444;
    issue(1'b0, 64'h0000_4008, 8'h00, 64'd0, c, 1'b0);
    wait_resp();
    check("t5_rdata", rdata, 64'h7777_6666_5555_4444);
    settle();
    check("t5_overlap", overlap_cnt - ov0, 64'd1);

    // async reset while ar_valid is pending
    make_cfg(c, 0); c.ar_dly = 10;
    issue(1'b0, 64'h0000_0040, 8'h00, 64'd0, c, 1'b0);
    check("t6_ar_pre", axi.ar_valid, 1'b1);
    req = 1'b1;
    #2 rst = 1'b1;
    cfg_q.delete();
    #1;
    check("t6_ar_rst", axi.ar_valid, 1'b0);
    check("t6_gnt_rst", gnt, 1'b0);
    check("t6_rvalid_rst", rvalid, 1'b0);
    repeat (2) @(posedge clk);
    #1 req = 1'b0;
    rst = 1'b0;
    settle();
    make_cfg(c, 0); c.rdata = 64'hCAFE_F00D_0000_0001;
    issue(1'b0, 64'h0000_1007, 8'h00, 64'd0, c, 1'b0);
    wait_resp();
    check("t6_rdata", rdata, 64'hCAFE_F00D_0000_0001);
    check("t6_err", err, 1'b0);
    settle();
    check("t6_latency", last_rv_cyc - last_grant_cyc, 64'd3);
    check("t6_ar_addr", last_ar_addr, 64'h0000_1000);

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      make_cfg(c, 1);
      keep = (i != 149) && ($urandom_range(0, 3) == 0);
      issue(1'($urandom_range(0, 1)), {$urandom, $urandom}, 8'($urandom_range(0, 255)),
            {$urandom, $urandom}, c, keep);
      if (!keep) begin
        repeat ($urandom_range(0, 2)) settle();
      end
    end
    repeat (40) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (checks %0d errors %0d)", checks, errors);
    $fatal(1);
  end
endmodule
